wt_l15_responder: RTL

Memory-side responder for the write-through data cache's L1.5-style request/response channel, using the big-endian NoC byte order. It accepts one load, store or instruction-fill request at a time and serves it from a local 64-bit-word memory after a fixed, programmable latency. It then returns a tagged response carrying the transaction ID. The block sits where the L1.5/NoC would be, so cache request generation can be exercised without OpenPiton in simulation and FPGA bring-up.

---
 rtl/wt_l15_resp_pkg.sv | 54 +++++
 rtl/wt_l15_resp_mem.sv | 42 ++++
 rtl/wt_l15_responder.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/wt_l15_resp_pkg.sv
// Shared types and helpers for the L1.5-style memory responder.
// Contents:
//   req_type_e    - request/response type encoding (LOAD/STORE/IFILL/reserved)
//   fsm_state_e   - responder control states
//   SIZE_*        - request size encodings (2^size bytes, 4 = 16-byte line)
//   bswap64       - reverse the byte order of a 64-bit word
//   be_mask       - byte enable (bit k = byte offset k) for an access
package wt_l15_resp_pkg;

    typedef enum logic [1:0] {
        REQ_LOAD  = 2'd0,
        REQ_STORE = 2'd1,
        REQ_IFILL = 2'd2,
        REQ_RSVD  = 2'd3
    } req_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } fsm_state_e;

    localparam logic [2:0] SIZE_1B   = 3'd0;
    localparam logic [2:0] SIZE_2B   = 3'd1;
    localparam logic [2:0] SIZE_4B   = 3'd2;
    localparam logic [2:0] SIZE_8B   = 3'd3;
    localparam logic [2:0] SIZE_LINE = 3'd4;

    // Memory keeps byte offset k in bits [8k+7:8k]; the bus carries it in
    // bits [63-8k -: 8]. One swap converts in either direction.
    function automatic logic [63:0] bswap64(input logic [63:0] w);
        logic [63:0] r;
        r = 64'd0;
        for (int k = 0; k < 8; k++) begin
            r[8*k +: 8] = w[63-8*k -: 8];
        end
        return r;
    endfunction

    // Enable for 2^size bytes starting at byte offset off. Line size has no
    // single-word meaning and yields no enables.
    function automatic logic [7:0] be_mask(input logic [2:0] off, input logic [2:0] size);
        logic [7:0] base;
        case (size)
            SIZE_1B: base = 8'h01;
            SIZE_2B: base = 8'h03;
            SIZE_4B: base = 8'h0F;
            SIZE_8B: base = 8'hFF;
            default: base = 8'h00;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/wt_l15_resp_mem.sv
// Word memory for the responder: MEM_WORDS x 64 bits, little-endian bytes.
// One synchronous write port with per-byte enables, two combinational read
// ports so both halves of a 16-byte line are available in the same cycle.
// Contents are not reset.
// Ports:
//   clk_i              clock
//   we_i, be_i         write strobe and byte enables (bit k = byte offset k)
//   waddr_i, wdata_i   write word index and data (memory byte order)
//   raddr0_i/rdata0_o  read port 0
//   raddr1_i/rdata1_o  read port 1
module wt_l15_resp_mem
    import wt_l15_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned IDX_W     = $clog2(MEM_WORDS)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [7:0]       be_i,
    input  logic [IDX_W-1:0] waddr_i,
    input  logic [63:0]      wdata_i,
    input  logic [IDX_W-1:0] raddr0_i,
    input  logic [IDX_W-1:0] raddr1_i,
    output logic [63:0]      rdata0_o,
    output logic [63:0]      rdata1_o
);

    logic [63:0] mem_q [MEM_WORDS];

    // Byte-masked write; unselected bytes keep their contents.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 8; b++) begin
            if (we_i && be_i[b]) begin
                mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/wt_l15_responder.sv
// Memory-side responder for the write-through cache's L1.5 channel.
// Accepts one request at a time, waits LATENCY cycles, performs the access
// against a local word memory and returns a registered, tagged response.
// Ports:
//   clk_i, rst_i                      clock, async active-high reset
//   req_valid_i / req_ready_o         request handshake
//   req_type_i, req_addr_i,
//   req_size_i, req_data_i, req_tid_i request fields (store data big-endian)
//   rsp_valid_o / rsp_ready_i         response handshake
//   rsp_type_o, rsp_tid_o,
//   rsp_data_o, rsp_err_o             response fields (data big-endian)
module wt_l15_responder
    import wt_l15_resp_pkg::*;
#(
    parameter int unsigned MEM_WORDS = 1024,
    parameter int unsigned LATENCY   = 3,
    parameter int unsigned TID_W     = 2,
    parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [1:0]       req_type_i,
    input  logic [63:0]      req_addr_i,
    input  logic [2:0]       req_size_i,
    input  logic [63:0]      req_data_i,
    input  logic [TID_W-1:0] req_tid_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [1:0]       rsp_type_o,
    output logic [TID_W-1:0] rsp_tid_o,
    output logic [127:0]     rsp_data_o,
    output logic             rsp_err_o
);

    localparam int unsigned      IDX_W     = $clog2(MEM_WORDS);
    localparam int unsigned      CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [63:0]      MEM_BYTES = 64'(MEM_WORDS) * 64'd8;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_W'(LATENCY - 1);

    fsm_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       type_q, type_d;
    logic [63:0]      addr_q, addr_d;
    logic [2:0]       size_q, size_d;
    logic [63:0]      data_q, data_d;
    logic [TID_W-1:0] tid_q, tid_d;
    logic [1:0]       rsp_type_q, rsp_type_d;
    logic [TID_W-1:0] rsp_tid_q, rsp_tid_d;
    logic [127:0]     rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;

    logic             hs_s, access_s, mem_we_s;
    logic [63:0]      off_s;
    logic             in_range_s, align_ok_s, err_s;
    logic [IDX_W-1:0] idx_s, raddr0_s, raddr1_s;
    logic [63:0]      rdata0_s, rdata1_s;

    // Control state and latency counter.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: IDLE -> WAIT on handshake, WAIT -> RESP when the count
    // expires, RESP -> IDLE when the response is consumed.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State decode: handshake flags and the single access strobe.
    always_comb begin
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        access_s    = 1'b0;
        case (state_q)
            ST_IDLE: req_ready_o = 1'b1;
            ST_WAIT: access_s    = (cnt_q == '0);
            ST_RESP: rsp_valid_o = 1'b1;
            default: req_ready_o = 1'b0;
        endcase
    end

    // Request capture registers and response registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            type_q     <= 2'd0;
            addr_q     <= 64'd0;
            size_q     <= 3'd0;
            data_q     <= 64'd0;
            tid_q      <= '0;
            rsp_type_q <= 2'd0;
            rsp_tid_q  <= '0;
            rsp_data_q <= 128'd0;
            rsp_err_q  <= 1'b0;
        end else begin
            type_q     <= type_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            data_q     <= data_d;
            tid_q      <= tid_d;
            rsp_type_q <= rsp_type_d;
            rsp_tid_q  <= rsp_tid_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
        end
    end

    // Latch the request only on a handshake; inputs are ignored otherwise.
    always_comb begin
        hs_s   = req_ready_o & req_valid_i;
        type_d = hs_s ? req_type_i : type_q;
        addr_d = hs_s ? req_addr_i : addr_q;
        size_d = hs_s ? req_size_i : size_q;
        data_d = hs_s ? req_data_i : data_q;
        tid_d  = hs_s ? req_tid_i  : tid_q;
    end

    // Address decode and error classification of the latched request.
    // Line accesses ignore addr[3:0], so only sub-line sizes check alignment.
    always_comb begin
        off_s      = addr_q - BASE_ADDR;
        in_range_s = (addr_q >= BASE_ADDR) && (off_s < MEM_BYTES);
        case (size_q)
            SIZE_1B: align_ok_s = 1'b1;
            SIZE_2B: align_ok_s = (addr_q[0] == 1'b0);
            SIZE_4B: align_ok_s = (addr_q[1:0] == 2'd0);
            SIZE_8B: align_ok_s = (addr_q[2:0] == 3'd0);
            default: align_ok_s = 1'b1;
        endcase
        err_s = !in_range_s || (type_q == REQ_RSVD) || (size_q > SIZE_LINE) || !align_ok_s
                || ((type_q == REQ_STORE) && (size_q == SIZE_LINE));
        idx_s    = off_s[IDX_W+2:3];
        raddr0_s = (size_q == SIZE_LINE) ? {idx_s[IDX_W-1:1], 1'b0} : idx_s;
        raddr1_s = {idx_s[IDX_W-1:1], 1'b1};
        mem_we_s = access_s && !err_s && (type_q == REQ_STORE);
    end

    // Response fields load once, on the access edge, and hold until the next.
    always_comb begin
        rsp_type_d = rsp_type_q;
        rsp_tid_d  = rsp_tid_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        if (access_s) begin
            rsp_type_d = type_q;
            rsp_tid_d  = tid_q;
            rsp_err_d  = err_s;
            if (err_s || (type_q == REQ_STORE)) begin
                rsp_data_d = 128'd0;
            end else if (size_q == SIZE_LINE) begin
                rsp_data_d = {bswap64(rdata0_s), bswap64(rdata1_s)};
            end else begin
                rsp_data_d = {bswap64(rdata0_s), 64'd0};
            end
        end else begin
            rsp_err_d = rsp_err_q;
        end
    end

    wt_l15_resp_mem #(
        .MEM_WORDS (MEM_WORDS),
        .IDX_W     (IDX_W)
    ) u_mem (
        .clk_i    (clk_i),
        .we_i     (mem_we_s),
        .be_i     (be_mask(addr_q[2:0], size_q)),
        .waddr_i  (idx_s),
        .wdata_i  (bswap64(data_q)),
        .raddr0_i (raddr0_s),
        .raddr1_i (raddr1_s),
        .rdata0_o (rdata0_s),
        .rdata1_o (rdata1_s)
    );

    assign rsp_type_o = rsp_type_q;
    assign rsp_tid_o  = rsp_tid_q;
    assign rsp_data_o = rsp_data_q;
    assign rsp_err_o  = rsp_err_q;

endmodule
